// File: rtl/ball_physics.sv
// Ball motion and collision stage for the pong datapath.
// Moves the ball once per frame_tick, bounces it off the top/bottom walls and
// both paddles, emits a held 2-bit paddle-hit code and one-clk miss pulses.
// Optional feature macro: BALL_SPEEDUP_EN (each paddle hit raises |dx| by one,
// saturating at MAX_SPEED_X). Without it |dx| stays at SPEED_X.
module ball_physics #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int P1_X        = 16,
    parameter int P2_X        = 624,
    parameter int SPEED_X     = 2,
    parameter int SPEED_Y     = 2,
    parameter int HIT_HOLD    = 4,
    parameter int MISS_FRAMES = 60,
    parameter int MAX_SPEED_X = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] paddle1_y,
    input  logic [9:0] paddle2_y,
    input  logic [9:0] paddle1_width,
    input  logic [9:0] paddle2_width,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] hit,
    output logic [1:0] miss,
    output logic [1:0] state
);

    localparam logic [9:0]        CX    = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]        CY    = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] BS    = 12'(BALL_SIZE);
    localparam logic signed [11:0] P1    = 12'(P1_X);
    localparam logic signed [11:0] P2    = 12'(P2_X);
    localparam logic signed [11:0] DY    = 12'(SPEED_Y);
    localparam int SPD_W = $clog2(MAX_SPEED_X + 1);
    localparam int HC_W  = $clog2(HIT_HOLD + 1);
    localparam int FC_W  = $clog2(MISS_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_MISS = 2'b10
    } state_t;

    state_t             st;
    logic               dx_neg;
    logic               dy_neg;
    logic [SPD_W-1:0]   speed;
    logic [HC_W-1:0]    hit_cnt;
    logic [FC_W-1:0]    frame_cnt;

    logic signed [11:0] spd_s, dx_s, dy_s, nx, ny;
    logic signed [11:0] p1_top, p1_end, p2_top, p2_end;
    logic               ov1, ov2;
    logic [9:0]         nxt_x, nxt_y;
    logic               nxt_dx_neg, nxt_dy_neg;
    logic [1:0]         hit_code, miss_code;

    // Left-edge saturation: a ball that overshoots paddle1 never goes below x = 0.
    function automatic logic [9:0] clamp_low(input logic signed [11:0] v);
        if (v < 12'sd0) return 10'd0;
        return v[9:0];
    endfunction

    // Vertical saturation against the top and bottom walls.
    function automatic logic [9:0] clamp_y(input logic signed [11:0] v);
        if (v <= 12'sd0) return 10'd0;
        if (v >= Y_MAX) return Y_MAX[9:0];
        return v[9:0];
    endfunction

    assign state = st;

    // Candidate position for the next frame plus wall and paddle outcomes.
    always_comb begin
        spd_s  = 12'(speed);
        dx_s   = dx_neg ? -spd_s : spd_s;
        dy_s   = dy_neg ? -DY : DY;
        nx     = $signed({2'b00, ball_x}) + dx_s;
        ny     = $signed({2'b00, ball_y}) + dy_s;
        p1_top = $signed({2'b00, paddle1_y});
        p1_end = p1_top + $signed({2'b00, paddle1_width});
        p2_top = $signed({2'b00, paddle2_y});
        p2_end = p2_top + $signed({2'b00, paddle2_width});
        // A zero-width paddle must never overlap, even though the range test alone could.
        ov1    = (paddle1_width != 10'd0) && (ny + BS > p1_top) && (ny < p1_end);
        ov2    = (paddle2_width != 10'd0) && (ny + BS > p2_top) && (ny < p2_end);

        nxt_y      = clamp_y(ny);
        nxt_dy_neg = dy_neg;
        if (ny <= 12'sd0)    nxt_dy_neg = 1'b0;
        else if (ny >= Y_MAX) nxt_dy_neg = 1'b1;

        nxt_x      = nx[9:0];
        nxt_dx_neg = dx_neg;
        hit_code   = 2'b00;
        miss_code  = 2'b00;
        if (dx_neg && (nx <= P1)) begin
            if (ov1) begin
                nxt_x      = P1[9:0];
                nxt_dx_neg = 1'b0;
                hit_code   = 2'b10;
            end else begin
                nxt_x     = clamp_low(nx);
                miss_code = 2'b10;
            end
        end else if (!dx_neg && (nx + BS >= P2)) begin
            if (ov2) begin
                nxt_x      = 10'(P2_X - BALL_SIZE);
                nxt_dx_neg = 1'b1;
                hit_code   = 2'b01;
            end else begin
                miss_code = 2'b01;
            end
        end
    end

`ifdef BALL_SPEEDUP_EN
    // One step of horizontal speed-up, capped at the ceiling.
    function automatic logic [SPD_W-1:0] sat_speed(input logic [SPD_W-1:0] s);
        if (s >= SPD_W'(MAX_SPEED_X)) return SPD_W'(MAX_SPEED_X);
        return s + 1'b1;
    endfunction

    // Horizontal speed: reload while idle, bump on every paddle hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            speed <= SPD_W'(SPEED_X);
        else if (st == S_IDLE)
            speed <= SPD_W'(SPEED_X);
        else if ((st == S_PLAY) && frame_tick && (hit_code != 2'b00))
            speed <= sat_speed(speed);
    end
`else
    assign speed = SPD_W'(SPEED_X);
`endif

    // Game FSM, ball position/direction, hit hold and miss pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= S_IDLE;
            ball_x    <= CX;
            ball_y    <= CY;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            hit       <= 2'b00;
            hit_cnt   <= '0;
            miss      <= 2'b00;
            frame_cnt <= '0;
        end else begin
            miss <= 2'b00;
            // The hit code is held for HIT_HOLD clocks and then dropped straight to 00.
            if (hit_cnt != '0) hit_cnt <= hit_cnt - 1'b1;
            else               hit     <= 2'b00;

            case (st)
                S_IDLE: begin
                    ball_x    <= CX;
                    ball_y    <= CY;
                    frame_cnt <= '0;
                    if (serve) st <= S_PLAY;
                end
                S_PLAY: begin
                    if (frame_tick) begin
                        ball_x <= nxt_x;
                        ball_y <= nxt_y;
                        dx_neg <= nxt_dx_neg;
                        dy_neg <= nxt_dy_neg;
                        if (hit_code != 2'b00) begin
                            hit     <= hit_code;
                            hit_cnt <= HC_W'(HIT_HOLD - 1);
                        end
                        // On a miss dx already points at the missing paddle, so the
                        // next serve heads that way without extra bookkeeping.
                        if (miss_code != 2'b00) begin
                            miss      <= miss_code;
                            st        <= S_MISS;
                            frame_cnt <= '0;
                        end
                    end
                end
                S_MISS: begin
                    if (frame_tick) begin
                        if (frame_cnt == FC_W'(MISS_FRAMES - 1)) begin
                            st        <= S_IDLE;
                            ball_x    <= CX;
                            ball_y    <= CY;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_physics.sv
// Testbench for ball_physics: directed scenarios followed by randomized play,
// every cycle compared against a behavioural game model kept in the bench.
module tb_ball_physics;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       serve;
    logic [9:0] paddle1_y, paddle2_y, paddle1_width, paddle2_width;
    logic [9:0] ball_x, ball_y;
    logic [1:0] hit, miss, state;

    int tests = 0;
    int fails = 0;

    // Reference model state (plain integers, game-level view)
    int m_state, m_x, m_y, m_dx, m_dy, m_hit, m_hold, m_miss, m_mcnt, m_spd;

    ball_physics dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .serve        (serve),
        .paddle1_y    (paddle1_y),
        .paddle2_y    (paddle2_y),
        .paddle1_width(paddle1_width),
        .paddle2_width(paddle2_width),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .hit          (hit),
        .miss         (miss),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit overlaps(input int ny, input int py, input int pw);
        return (pw != 0) && (ny + 8 > py) && (ny < py + pw);
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = 316; m_y = 236; m_spd = 2; m_dx = 2; m_dy = 2;
        m_hit = 0; m_hold = 0; m_miss = 0; m_mcnt = 0;
    endtask

    task automatic model_clock(input logic srv, input logic tk);
        int nx, ny;
        m_miss = 0;
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_hit = 0;
        end
        if (m_state == 0) begin
            m_x = 316; m_y = 236; m_spd = 2;
            m_dx = (m_dx < 0) ? -m_spd : m_spd;
            if (srv) m_state = 1;
        end else if (m_state == 1) begin
            if (tk) begin
                nx = m_x + m_dx;
                ny = m_y + m_dy;
                if (ny <= 0)        begin m_y = 0;   m_dy = 2;  end
                else if (ny >= 472) begin m_y = 472; m_dy = -2; end
                else                m_y = ny;
                if (m_dx < 0 && nx <= 16) begin
                    if (overlaps(ny, int'(paddle1_y), int'(paddle1_width))) begin
`ifdef BALL_SPEEDUP_EN
                        if (m_spd < 6) m_spd++;
`endif
                        m_x = 16; m_dx = m_spd; m_hit = 2; m_hold = 4;
                    end else begin
                        m_x = (nx < 0) ? 0 : nx; m_miss = 2; m_state = 2; m_mcnt = 0;
                    end
                end else if (m_dx > 0 && nx + 8 >= 624) begin
                    if (overlaps(ny, int'(paddle2_y), int'(paddle2_width))) begin
`ifdef BALL_SPEEDUP_EN
                        if (m_spd < 6) m_spd++;
`endif
                        m_x = 616; m_dx = -m_spd; m_hit = 1; m_hold = 4;
                    end else begin
                        m_x = nx; m_miss = 1; m_state = 2; m_mcnt = 0;
                    end
                end else begin
                    m_x = nx;
                end
            end
        end else begin
            if (tk) begin
                m_mcnt++;
                if (m_mcnt == 60) begin
                    m_state = 0; m_x = 316; m_y = 236; m_mcnt = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_x"},     {6'd0, ball_x}, 16'(m_x));
        chk({tag, "_y"},     {6'd0, ball_y}, 16'(m_y));
        chk({tag, "_hit"},   {14'd0, hit},   16'(m_hit));
        chk({tag, "_miss"},  {14'd0, miss},  16'(m_miss));
        chk({tag, "_state"}, {14'd0, state}, 16'(m_state));
    endtask

    task automatic step(input logic srv, input logic tk);
        serve      = srv;
        frame_tick = tk;
        model_clock(srv, tk);
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic frame(input int gap);
        step(1'b0, 1'b1);
        for (int i = 1; i < gap; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        serve = 1'b0; frame_tick = 1'b0;
        reset = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all(tag);
    endtask

    task automatic rand_paddles();
        int mode;
        mode = $urandom_range(0, 3);
        paddle1_y = 10'($urandom_range(0, 479));
        paddle1_width = (mode == 0) ? 10'd0 : (mode == 1) ? 10'd480 :
                        (mode == 2) ? 10'($urandom_range(1, 200)) : 10'($urandom_range(0, 1023));
        mode = $urandom_range(0, 3);
        paddle2_y = 10'($urandom_range(0, 479));
        paddle2_width = (mode == 0) ? 10'd0 : (mode == 1) ? 10'd480 :
                        (mode == 2) ? 10'($urandom_range(1, 200)) : 10'($urandom_range(0, 1023));
    endtask

    initial begin
        reset = 1'b0; serve = 1'b0; frame_tick = 1'b0;
        paddle1_y = 10'd0; paddle1_width = 10'd480;
        paddle2_y = 10'd0; paddle2_width = 10'd480;
        #1;
        do_reset("por");
        chk("por_state", {14'd0, state}, 16'd0);

        // Reset in the middle of play returns everything to the centre/IDLE
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) frame(8);
        do_reset("t1");
        chk("t1_x", {6'd0, ball_x}, 16'd316);
        chk("t1_state", {14'd0, state}, 16'd0);

        // Serve toward a full-height paddle2; wall bounce at 472 on the way
        step(1'b1, 1'b0);
        for (int i = 1; i < 150; i++) begin
            frame(8);
            if (i == 118) begin
                chk("t4_y", {6'd0, ball_y}, 16'd472);
                chk("t4_hit", {14'd0, hit}, 16'd0);
                chk("t4_miss", {14'd0, miss}, 16'd0);
            end
        end
        step(1'b0, 1'b1);
        chk("t2_x", {6'd0, ball_x}, 16'd616);
        chk("t2_hit0", {14'd0, hit}, 16'd1);
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b0);
            chk("t2_hold", {14'd0, hit}, 16'd1);
        end
        step(1'b0, 1'b0);
        chk("t2_drop", {14'd0, hit}, 16'd0);
        for (int i = 5; i < 8; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("t2_dx", {6'd0, ball_x}, 16'd614);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b0);

        // Ball heads left toward a short paddle1 placed far below it
        paddle1_y = 10'd400; paddle1_width = 10'd50;
        for (int i = 0; i < 298; i++) frame(8);
        step(1'b0, 1'b1);
        chk("t3_miss", {14'd0, miss}, 16'd2);
        chk("t3_state", {14'd0, state}, 16'd2);
        step(1'b0, 1'b0);
        chk("t3_pulse", {14'd0, miss}, 16'd0);
        for (int i = 2; i < 8; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 59; i++) frame(8);
        step(1'b0, 1'b1);
        chk("t3_idle", {14'd0, state}, 16'd0);
        chk("t3_cx", {6'd0, ball_x}, 16'd316);
        chk("t3_cy", {6'd0, ball_y}, 16'd236);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("t3_dir", {6'd0, ball_x}, 16'd314);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b0);

        // Paddle1 hit, then reset on the second clock of the hold
        paddle1_y = 10'd0; paddle1_width = 10'd480;
        for (int i = 0; i < 148; i++) frame(8);
        step(1'b0, 1'b1);
        chk("t5_hit", {14'd0, hit}, 16'd2);
        step(1'b0, 1'b0);
        chk("t5_hold", {14'd0, hit}, 16'd2);
        do_reset("t5");
        chk("t5_clr", {14'd0, hit}, 16'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            chk("t5_nohit", {14'd0, hit}, 16'd0);
        end

        // Randomized play against the model
        rand_paddles();
        for (int f = 0; f < 1500; f++) begin
            int gap;
            if ($urandom_range(0, 7) == 0) rand_paddles();
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            gap = $urandom_range(6, 12);
            step(1'($urandom_range(0, 3) == 0), 1'b1);
            for (int c = 1; c < gap; c++) step(1'($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
